// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared pipeline constants and types for hazard stall control
package stall_ctrl_pkg;
  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam int NEED_W = 2;
  typedef enum logic {RUN, STALL} state_e;
  typedef logic [NEED_W-1:0] need_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one destination register against both ID sources; X31 never hits
module hazard_match
  import stall_ctrl_pkg::*;
(
  input  logic       wr_i,
  input  logic [4:0] dst_i,
  input  logic [4:0] rn_i,
  input  logic [4:0] rm_i,
  input  logic       use_rn_i,
  input  logic       use_rm_i,
  output logic       hit_o
);
  assign hit_o = wr_i && dst_i != ZERO_REG &&
                 ((use_rn_i && dst_i == rn_i) || (use_rm_i && dst_i == rm_i));
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush control with fixed-length stalls and a saturating bubble counter
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fwdEN,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       targetReg_EX,
  input  logic [4:0]       targetReg_MEM,
  input  logic [4:0]       Rn_ID,
  input  logic [4:0]       Rm_ID,
  input  logic             usesRn_ID,
  input  logic             usesRm_ID,
  input  logic             brTaken_ID,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             stalling,
  output logic [CNT_W-1:0] stallCycles
);
  state_e           state_q, state_d;
  need_t            rem_q, rem_d, need;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_hit, mem_hit, lu_hit, bub;
  hazard_match u_ex (
    .wr_i(RegWrite_EX), .dst_i(targetReg_EX), .rn_i(Rn_ID), .rm_i(Rm_ID),
    .use_rn_i(usesRn_ID), .use_rm_i(usesRm_ID), .hit_o(ex_hit)
  );
  hazard_match u_mem (
    .wr_i(RegWrite_MEM), .dst_i(targetReg_MEM), .rn_i(Rn_ID), .rm_i(Rm_ID),
    .use_rn_i(usesRn_ID), .use_rm_i(usesRm_ID), .hit_o(mem_hit)
  );
  hazard_match u_lu (
    .wr_i(RegWrite_EX && MemRead_EX), .dst_i(targetReg_EX), .rn_i(Rn_ID), .rm_i(Rm_ID),
    .use_rn_i(usesRn_ID), .use_rm_i(usesRm_ID), .hit_o(lu_hit)
  );
  // need is only consulted in RUN; in STALL the length latched in rem_q rules
  always_comb begin
    need    = fwdEN ? (lu_hit ? need_t'(1) : need_t'(0))
                    : ex_hit ? need_t'(2) : mem_hit ? need_t'(1) : need_t'(0);
    bub     = !reset && (state_q == STALL || need != '0);
    rem_d   = state_q == STALL ? rem_q - need_t'(1) : (need != '0 ? need - need_t'(1) : '0);
    state_d = rem_d != '0 ? STALL : RUN;
    cnt_d   = (bub && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end
  assign PCWrite     = !bub;
  assign IFID_Write  = !bub;
  assign IDEX_Bubble = bub;
  assign IFID_Flush  = !reset && state_q == RUN && brTaken_ID && need == '0;
  assign stalling    = !reset && state_q == STALL;
  assign stallCycles = cnt_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed scoreboard bench for stall_ctrl (CNT_W=16 and a saturating CNT_W=2 copy)
module tb_stall_ctrl;
  logic clk = 0, reset = 1;
  logic fwdEN, MemRead_EX, RegWrite_EX, RegWrite_MEM, usesRn_ID, usesRm_ID, brTaken_ID;
  logic [4:0] targetReg_EX, targetReg_MEM, Rn_ID, Rm_ID;
  logic pcw, ifw, bub, fl, st, pcw2, ifw2, bub2, fl2, st2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  typedef struct {
    string tag;
    logic pcw, bub, fl, st;
    logic [15:0] c;
    logic [1:0] c2;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  logic [15:0] exp_cnt = 0;
  logic [1:0] exp_cnt2 = 0;
  always #5 clk = ~clk;
  stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .fwdEN(fwdEN), .MemRead_EX(MemRead_EX),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM),
    .targetReg_EX(targetReg_EX), .targetReg_MEM(targetReg_MEM),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .usesRn_ID(usesRn_ID), .usesRm_ID(usesRm_ID),
    .brTaken_ID(brTaken_ID), .PCWrite(pcw), .IFID_Write(ifw), .IDEX_Bubble(bub),
    .IFID_Flush(fl), .stalling(st), .stallCycles(cnt)
  );
  stall_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .fwdEN(fwdEN), .MemRead_EX(MemRead_EX),
    .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM),
    .targetReg_EX(targetReg_EX), .targetReg_MEM(targetReg_MEM),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .usesRn_ID(usesRn_ID), .usesRm_ID(usesRm_ID),
    .brTaken_ID(brTaken_ID), .PCWrite(pcw2), .IFID_Write(ifw2), .IDEX_Bubble(bub2),
    .IFID_Flush(fl2), .stalling(st2), .stallCycles(cnt2)
  );
  task automatic chk(string tag, string f, logic [15:0] obs, logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, want);
    end
  endtask
  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, "PCWrite", 16'(pcw), 16'(e.pcw));
    chk(e.tag, "IFID_Write", 16'(ifw), 16'(e.pcw));
    chk(e.tag, "IDEX_Bubble", 16'(bub), 16'(e.bub));
    chk(e.tag, "IFID_Flush", 16'(fl), 16'(e.fl));
    chk(e.tag, "stalling", 16'(st), 16'(e.st));
    chk(e.tag, "stallCycles", cnt, e.c);
    chk(e.tag, "w2_ctrl", 16'({pcw2, ifw2, bub2, fl2, st2}), 16'({e.pcw, e.pcw, e.bub, e.fl, e.st}));
    chk(e.tag, "w2_stallCycles", 16'(cnt2), 16'(e.c2));
  endtask
  task automatic step(string tag, logic p, logic b, logic f, logic s);
    sb.push_back('{tag, p, b, f, s, exp_cnt, exp_cnt2});
    @(negedge clk);
    check_front();
    @(posedge clk);
    if (b && !reset) begin
      exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
    end
    #1;
  endtask
  task automatic clr();
    fwdEN = 1; MemRead_EX = 0; RegWrite_EX = 0; RegWrite_MEM = 0;
    targetReg_EX = 0; targetReg_MEM = 0; Rn_ID = 0; Rm_ID = 0;
    usesRn_ID = 0; usesRm_ID = 0; brTaken_ID = 0;
  endtask
  task automatic load_use();
    fwdEN = 1; MemRead_EX = 1; RegWrite_EX = 1; targetReg_EX = 5; Rn_ID = 5; usesRn_ID = 1;
  endtask
  task automatic ex_nofwd();
    fwdEN = 0; RegWrite_EX = 1; targetReg_EX = 9; Rm_ID = 9; usesRm_ID = 1;
  endtask
  initial begin
    clr();
    ex_nofwd();
    brTaken_ID = 1;
    #1;
    step("reset_gated", 1, 0, 0, 0);
    reset = 0;
    clr();
    step("idle", 1, 0, 0, 0);
    load_use();
    step("lu_bubble", 0, 1, 0, 0);
    clr();
    step("lu_done", 1, 0, 0, 0);
    fwdEN = 1; RegWrite_MEM = 1; targetReg_MEM = 7; Rn_ID = 7; usesRn_ID = 1;
    step("mem_fwd_ignored", 1, 0, 0, 0);
    fwdEN = 0;
    step("mem_nofwd", 0, 1, 0, 0);
    clr();
    step("mem_nofwd_done", 1, 0, 0, 0);
    ex_nofwd();
    step("ex_b1", 0, 1, 0, 0);
    clr();
    fwdEN = 1;
    step("ex_b2_fixed", 0, 1, 0, 1);
    step("ex_done", 1, 0, 0, 0);
    fwdEN = 1; MemRead_EX = 1; RegWrite_EX = 1; targetReg_EX = 31;
    Rn_ID = 31; usesRn_ID = 1; Rm_ID = 31; usesRm_ID = 0;
    step("x31_load", 1, 0, 0, 0);
    targetReg_EX = 4; Rn_ID = 3; Rm_ID = 4;
    step("unused_rm", 1, 0, 0, 0);
    fwdEN = 0; targetReg_EX = 31; Rn_ID = 31;
    step("x31_nofwd", 1, 0, 0, 0);
    clr();
    load_use();
    brTaken_ID = 1;
    step("br_lu_stall", 0, 1, 0, 0);
    clr();
    brTaken_ID = 1;
    step("br_flush", 1, 0, 1, 0);
    clr();
    step("br_done", 1, 0, 0, 0);
    ex_nofwd();
    brTaken_ID = 1;
    step("br_ex_b1", 0, 1, 0, 0);
    clr();
    brTaken_ID = 1;
    step("br_ex_b2", 0, 1, 0, 1);
    step("br_ex_flush", 1, 0, 1, 0);
    clr();
    ex_nofwd();
    step("rst_ex_b1", 0, 1, 0, 0);
    reset = 1;
    exp_cnt = 0;
    exp_cnt2 = 0;
    sb.push_back('{"rst_async", 1, 0, 0, 0, exp_cnt, exp_cnt2});
    #1;
    check_front();
    step("rst_hold", 1, 0, 0, 0);
    reset = 0;
    clr();
    load_use();
    for (int i = 0; i < 5; i++) step("sat_lu", 0, 1, 0, 0);
    clr();
    step("sat_done", 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
